// File: rtl/bus_rr_arbiter4_if.sv
// Bundle of request, data and grant signals shared between four requesters,
// the round-robin arbiter and the single downstream valid/ready sink.
interface bus_rr_arbiter4_if #(
    parameter int WIDTH = 32
);
    logic [3:0]       req;
    logic [WIDTH-1:0] datain0;
    logic [WIDTH-1:0] datain1;
    logic [WIDTH-1:0] datain2;
    logic [WIDTH-1:0] datain3;
    logic             out_ready;
    logic [3:0]       gnt;
    logic [1:0]       select;
    logic [WIDTH-1:0] dataout;
    logic             out_valid;
    logic [3:0]       ack;

    // master: requesters plus the downstream sink; slave: the arbiter itself
    modport master (
        output req, datain0, datain1, datain2, datain3, out_ready,
        input  gnt, select, dataout, out_valid, ack
    );

    modport slave (
        input  req, datain0, datain1, datain2, datain3, out_ready,
        output gnt, select, dataout, out_valid, ack
    );
endinterface

// File: rtl/bus_rr_arbiter4.sv
// Four-way round-robin arbiter with burst-bounded grants and owned 4:1 data select.
// Grant 1 cycle after request; one beat/cycle while granted; 1 idle bubble between grants.
module bus_rr_arbiter4 #(
    parameter int WIDTH     = 32,
    parameter int MAX_BURST = 4
) (
    input  logic               clk,
    input  logic               rst,
    bus_rr_arbiter4_if.slave   bus
);
    localparam int CNT_W = $clog2(MAX_BURST) + 1;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t           state_q;
    logic [3:0]       gnt_q;
    logic [1:0]       select_q;
    logic [1:0]       ptr_q;
    logic [CNT_W-1:0] cnt_q;

    logic [1:0]       winner_d;
    logic [1:0]       cand;
    logic             any_req;
    logic             out_valid;
    logic             accept;
    logic             last_beat;
    logic             release_now;
    logic [WIDTH-1:0] mux_dat;

    // Scan from lowest priority to highest so the last hit is the first set bit from ptr.
    always_comb begin
        winner_d = ptr_q;
        cand     = ptr_q;
        any_req  = |bus.req;
        for (int k = 3; k >= 0; k--) begin
            cand = ptr_q + 2'(k);
            if (bus.req[cand]) begin
                winner_d = cand;
            end
        end
    end

    assign out_valid   = (state_q == GRANT) && bus.req[select_q];
    assign accept      = out_valid && bus.out_ready;
    assign last_beat   = (cnt_q == CNT_W'(MAX_BURST - 1));
    assign release_now = (accept && last_beat) || !bus.req[select_q];

    always_comb begin
        mux_dat = bus.datain0;
        unique case (select_q)
            2'd0:    mux_dat = bus.datain0;
            2'd1:    mux_dat = bus.datain1;
            2'd2:    mux_dat = bus.datain2;
            default: mux_dat = bus.datain3;
        endcase
    end

    assign bus.gnt       = gnt_q;
    assign bus.select    = select_q;
    assign bus.dataout   = mux_dat;
    assign bus.out_valid = out_valid;
    assign bus.ack       = accept ? gnt_q : 4'b0000;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            gnt_q    <= 4'b0000;
            select_q <= 2'd0;
            ptr_q    <= 2'd0;
            cnt_q    <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (any_req) begin
                        state_q  <= GRANT;
                        select_q <= winner_d;
                        gnt_q    <= 4'b0001 << winner_d;
                        cnt_q    <= '0;
                    end
                end
                GRANT: begin
                    // select is left alone on release so dataout stays stable in the bubble
                    if (release_now) begin
                        state_q <= IDLE;
                        gnt_q   <= 4'b0000;
                        ptr_q   <= select_q + 2'd1;
                    end else if (accept) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    gnt_q   <= 4'b0000;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_bus_rr_arbiter4.sv
// Bench for bus_rr_arbiter4: transaction-level arbitration model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_bus_rr_arbiter4;
    localparam int W  = 32;
    localparam int MB = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bus_rr_arbiter4_if #(.WIDTH(W)) bus ();

    bus_rr_arbiter4 #(.WIDTH(W), .MAX_BURST(MB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    // Model: who owns the bus (-1 when idle), last chosen index, priority start, beats taken.
    int m_owner = -1;
    int m_sel   = 0;
    int m_prio  = 0;
    int m_beats = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_owner = -1;
            m_sel   = 0;
            m_prio  = 0;
            m_beats = 0;
        end else if (m_owner < 0) begin
            if (bus.req != 4'b0000) begin
                for (int k = 0; k < 4; k++) begin
                    if (m_owner < 0 && bus.req[(m_prio + k) % 4]) m_owner = (m_prio + k) % 4;
                end
                m_sel   = m_owner;
                m_beats = 0;
            end
        end else if (bus.req[m_owner] && bus.out_ready) begin
            m_beats++;
            if (m_beats == MB) begin
                m_prio  = (m_owner + 1) % 4;
                m_owner = -1;
            end
        end else if (!bus.req[m_owner]) begin
            m_prio  = (m_owner + 1) % 4;
            m_owner = -1;
        end
    end

    always @(negedge clk) begin
        logic [3:0]   eg;
        logic [3:0]   ea;
        logic         eov;
        logic [W-1:0] ed;
        eg  = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
        eov = (m_owner >= 0) && bus.req[m_owner];
        ea  = (eov && bus.out_ready) ? eg : 4'b0000;
        case (m_sel)
            0:       ed = bus.datain0;
            1:       ed = bus.datain1;
            2:       ed = bus.datain2;
            default: ed = bus.datain3;
        endcase
        chk("model_gnt", 32'(bus.gnt), 32'(eg));
        chk("model_select", 32'(bus.select), 32'(m_sel));
        chk("model_out_valid", 32'(bus.out_valid), 32'(eov));
        chk("model_ack", 32'(bus.ack), 32'(ea));
        chk("model_dataout", bus.dataout, ed);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        bus.req       = 4'b0000;
        bus.out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    logic rp [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

    initial begin
        bus.req       = 4'b0000;
        bus.out_ready = 1'b0;
        bus.datain0   = 32'hA0;
        bus.datain1   = 32'hA1;
        bus.datain2   = 32'hA2;
        bus.datain3   = 32'hA3;
        do_reset();

        // reset state
        #1;
        chk("rst_gnt", 32'(bus.gnt), 32'h0);
        chk("rst_select", 32'(bus.select), 32'h0);
        chk("rst_dataout", bus.dataout, 32'hA0);

        // single requester, full burst then regrant
        bus.out_ready = 1'b1;
        bus.req       = 4'b0001;
        #1;
        chk("t1_pre_gnt", 32'(bus.gnt), 32'h0);
        chk("t1_pre_ov", 32'(bus.out_valid), 32'h0);
        for (int b = 0; b < 4; b++) begin
            tick(); #1;
            chk("t1_gnt", 32'(bus.gnt), 32'h1);
            chk("t1_select", 32'(bus.select), 32'h0);
            chk("t1_ack", 32'(bus.ack), 32'h1);
        end
        tick(); #1;
        chk("t1_bubble_ov", 32'(bus.out_valid), 32'h0);
        chk("t1_bubble_gnt", 32'(bus.gnt), 32'h0);
        tick(); #1;
        chk("t1_regrant", 32'(bus.gnt), 32'h1);
        bus.req = 4'b0000;
        tick();

        // round-robin fairness with all four requesting
        do_reset();
        bus.out_ready = 1'b1;
        bus.req       = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            for (int b = 0; b < 4; b++) begin
                tick(); #1;
                chk("t2_gnt", 32'(bus.gnt), 32'(1 << (g % 4)));
                chk("t2_dataout", bus.dataout, 32'hA0 + 32'(g % 4));
                chk("t2_ack", 32'(bus.ack), 32'(1 << (g % 4)));
            end
            tick(); #1;
            chk("t2_bubble_ov", 32'(bus.out_valid), 32'h0);
        end

        // pointer wrap from requester 3 back to 0
        do_reset();
        bus.out_ready = 1'b1;
        bus.req       = 4'b1000;
        for (int b = 0; b < 4; b++) begin
            tick(); #1;
            chk("t3_gnt", 32'(bus.gnt), 32'h8);
            if (b == 3) bus.req = 4'b1001;
        end
        tick(); #1;
        chk("t3_bubble_gnt", 32'(bus.gnt), 32'h0);
        tick(); #1;
        chk("t3_wrap_gnt", 32'(bus.gnt), 32'h1);
        chk("t3_wrap_select", 32'(bus.select), 32'h0);

        // back-pressure: ready pattern 1,0,0,1,1,1
        do_reset();
        bus.out_ready = 1'b1;
        bus.req       = 4'b0100;
        for (int c = 0; c < 6; c++) begin
            tick();
            bus.out_ready = rp[c];
            #1;
            chk("t4_gnt", 32'(bus.gnt), 32'h4);
            chk("t4_ack", 32'(bus.ack), rp[c] ? 32'h4 : 32'h0);
        end
        tick();
        bus.out_ready = 1'b1;
        #1;
        chk("t4_release_gnt", 32'(bus.gnt), 32'h0);

        // withdrawal after two beats
        do_reset();
        bus.out_ready = 1'b1;
        bus.req       = 4'b0010;
        for (int c = 0; c < 2; c++) begin
            tick(); #1;
            chk("t5_gnt", 32'(bus.gnt), 32'h2);
            chk("t5_ack", 32'(bus.ack), 32'h2);
        end
        tick();
        bus.req = 4'b0100;
        #1;
        chk("t5_drop_ov", 32'(bus.out_valid), 32'h0);
        chk("t5_drop_ack", 32'(bus.ack), 32'h0);
        chk("t5_drop_gnt", 32'(bus.gnt), 32'h2);
        tick(); #1;
        chk("t5_bubble_gnt", 32'(bus.gnt), 32'h0);
        tick(); #1;
        chk("t5_next_gnt", 32'(bus.gnt), 32'h4);
        chk("t5_next_select", 32'(bus.select), 32'h2);

        // asynchronous reset during second beat of requester 3
        do_reset();
        bus.out_ready = 1'b1;
        bus.req       = 4'b1000;
        tick(); #1;
        tick(); #1;
        chk("t6_beat2_ack", 32'(bus.ack), 32'h8);
        #1;
        rst = 1'b1;
        #1;
        chk("t6_rst_gnt", 32'(bus.gnt), 32'h0);
        chk("t6_rst_select", 32'(bus.select), 32'h0);
        chk("t6_rst_ov", 32'(bus.out_valid), 32'h0);
        chk("t6_rst_ack", 32'(bus.ack), 32'h0);
        chk("t6_rst_dataout", bus.dataout, 32'hA0);
        bus.req = 4'b1111;
        tick();
        rst = 1'b0;
        tick(); #1;
        chk("t6_post_gnt", 32'(bus.gnt), 32'h1);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/bus_rr_arbiter4.md
# bus_rr_arbiter4

Four-requester round-robin arbiter that shares one 32-bit datapath between four masters. It owns the 4:1 data select: it registers a 2-bit `select` and a one-hot grant, and steers the chosen requester's data to a single valid/ready output toward the shared resource. Each grant is a burst that is bounded by `MAX_BURST` accepted beats, so one requester cannot starve the others.

## Interface
Parameters:
- `WIDTH`, 32, data width of every input and output data port.
- `MAX_BURST`, 4, maximum accepted beats per grant (legal range 1–15).

Ports:
- `clk`  in  1  — the single clock; all state changes on its rising edge.
- `rst`  in  1  — reset, asynchronous and active-high.
- `req`  in  4  — `req[i]` high while requester i has a beat to send.
- `datain0..datain3`  in  WIDTH each  — requester data, sampled when the beat is accepted.
- `out_ready`  in  1  — the shared resource can accept a beat this cycle.
- `gnt`  out  4  — one-hot registered grant, or all zero.
- `select`  out  2  — registered index of the granted requester.
- `dataout`  out  WIDTH  — combinational mux of `datain[select]`.
- `out_valid`  out  1  — a beat is offered on `dataout`.
- `ack`  out  4  — one-hot pulse: requester i's beat is accepted this cycle.

## Operation
- State machine has two states: IDLE and GRANT. Other registers: `ptr[1:0]` (highest-priority index) and `cnt` (beats accepted in the current grant, width ≥ clog2(MAX_BURST)+1).
- **IDLE:**
  - If `req != 0`, pick the first set bit scanning `ptr`, `ptr+1`, … modulo 4.
  - On the next edge: `select` ← winner, `gnt` ← one-hot(winner), `cnt` ← 0, state → GRANT.
  - If `req == 0`, stay in IDLE with `gnt == 0`.
- **GRANT:**
  - `out_valid = req[select]` (combinational). `out_valid` is 0 in IDLE.
  - A beat is accepted when `out_valid & out_ready`. In that cycle `ack = gnt`; otherwise `ack = 0`.
  - On each accepted beat, `cnt` increments.
- **Release** happens at the edge where either condition holds:
  - (a) a beat is accepted and `cnt == MAX_BURST-1`, or
  - (b) `req[select] == 0`.
- **On release:**
  - state → IDLE, `gnt` ← 0, `ptr` ← `select+1` (wraps 3→0).
  - `select` holds its value, so `dataout` stays stable.
- Requester contract: hold `req` and stable data until `ack`. `req` may be dropped at any time; dropping `req` withdraws the offer (condition b).
- `dataout` has no data-dependent arithmetic. It is a pure select.

## Timing
- **Reset values:** state IDLE, `gnt`=0, `select`=0, `ptr`=0, `cnt`=0, `out_valid`=0, `ack`=0, `dataout`=`datain0`. Reset takes effect immediately, without waiting for `clk`.
- **Latency:** `req` rising in IDLE → `gnt` and `out_valid` high 1 cycle later. First `ack` occurs in that same cycle if `out_ready`=1.
- **Back-to-back throughput:** one beat per cycle within a grant.
- **Bubble between grants:** exactly 1 cycle in IDLE with `out_valid`=0, even when another request is pending.
- **Last beat and `req` drop in the same cycle:** single release, `ptr` advances once.
- **`out_ready` low:** grant holds indefinitely and `cnt` does not advance. There is no timeout.
- **`MAX_BURST`=1:** release after every accepted beat.
- **Reset mid-burst:** immediate IDLE with all outputs at reset values. The interrupted beat is not acked.
- **`req` changes in IDLE:** arbitration samples `req` on the granting edge only.

## Test plan
- **Single requester:** after reset, `req`=0001 and `out_ready`=1 with `MAX_BURST`=4 → `gnt`=0001 and `select`=0 one cycle later. `ack[0]` pulses in 4 consecutive cycles, then 1 IDLE cycle, then re-grant to 0.
- **Round-robin fairness:** `req`=1111 held, `out_ready`=1, `datain_i`=32'hA0+i → grant order 0,1,2,3,0. `dataout` values are A0×4, A1×4, A2×4, A3×4, each group followed by 1 bubble.
- **Pointer wrap:** grant 3 completes while `req`=1001 → next grant goes to 0, not 3. `ptr` = 0.
- **Back-pressure:** `req`=0100 with `out_ready` toggling 1,0,0,1,1,1 → `ack[2]` only in the `out_ready`=1 cycles. Release after the 4th ack.
- **Withdrawal:** requester 1 granted, drops `req` after 2 acks → `out_valid` low that cycle. Release at the next edge, `ptr`=2, requester 2 granted after 1 bubble.
- **Asynchronous reset mid-burst:** assert `rst` between clock edges during beat 2 of requester 3 → `gnt`=0, `select`=0, `out_valid`=0, `ack`=0 immediately. After release of `rst` with `req`=1111, the first grant goes to 0.
